// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the req/ack word-transfer handshake (transmitter and receiver).
`timescale 1ns/1ps
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      WAIT_REL = 2'd2
   } hs_state_t;

   // A zero-cycle timeout still needs a 1-bit counter so the RTL stays legal.
   function automatic int timeout_cnt_w(input int cyc);
      return (cyc < 1) ? 1 : $clog2(cyc + 1);
   endfunction

endpackage

// File: rtl/BitSync.sv
// Multi-flop level synchronizer into the clk domain; each bit is synchronized independently.
`timescale 1ns/1ps
module BitSync #(
   parameter int Num_Stages = 2,
   parameter int Bus_Width  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [Bus_Width-1:0] d,
   output logic [Bus_Width-1:0] q
);

   logic [Num_Stages-1:0][Bus_Width-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[Num_Stages-2:0], d};
      end
   end

   assign q = sync_q[Num_Stages-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack word transfer; holds cdc_data stable while the handshake runs.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  IDLE     | tx_ready=1, cdc_req=0; a valid word is captured and req raised
//  WAIT_ACK | cdc_req=1, waiting for the synchronized ack to rise
//  WAIT_REL | cdc_req=0, waiting for the synchronized ack to fall; then tx_done
`timescale 1ns/1ps
module cdc_hs_tx
   import cdc_hs_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int NUM_STAGES  = 2,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] cdc_data,
   output logic              cdc_req,
   input  logic              cdc_ack_async,
   output logic              tx_done,
   output logic              busy,
   output logic              timeout_err,
   input  logic              err_clr
);

   localparam int             CNT_W    = timeout_cnt_w(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   hs_state_t        state;
   logic             ack_s;
   logic [CNT_W-1:0] to_cnt;
   logic             state_chg;
   logic             waiting;
   logic             timeout_hit;

   BitSync #(
      .Num_Stages (NUM_STAGES),
      .Bus_Width  (1)
   ) u_ack_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cdc_ack_async),
      .q     (ack_s)
   );

   assign tx_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign waiting  = (state == WAIT_ACK) || (state == WAIT_REL);

   assign state_chg = ((state == IDLE)     &&  tx_valid) ||
                      ((state == WAIT_ACK) &&  ack_s)    ||
                      ((state == WAIT_REL) && !ack_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cdc_req  <= 1'b0;
         cdc_data <= '0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  cdc_data <= tx_data;
                  cdc_req  <= 1'b1;
                  state    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ack_s) begin
                  cdc_req <= 1'b0;
                  state   <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (!ack_s) begin
                  tx_done <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               cdc_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // The error only flags a slow phase; the FSM keeps waiting so the protocol order holds.
   assign timeout_hit = (TIMEOUT_CYC > 0) && waiting && !state_chg && (to_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_chg || !waiting || (TIMEOUT_CYC == 0)) begin
            to_cnt <= '0;
         end else if (to_cnt != CNT_MAX) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: async receiver model echoes req->ack, scoreboard checks every captured word.
`timescale 1ns/1ps
module tb_cdc_hs_tx;

   logic       clk = 1'b0;
   logic       clk_dst = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] cdc_data;
   logic       cdc_req;
   logic       cdc_ack_async;
   logic       tx_done;
   logic       busy;
   logic       timeout_err;
   logic       err_clr;

   int n_chk = 0;
   int n_err = 0;
   int n_sent = 0;
   int n_done = 0;
   int n_abort = 0;

   logic [7:0] exp_q[$];

   realtime dst_half = 3.5;

   always #5 clk = ~clk;
   initial begin
      #1.3;
      forever #(dst_half) clk_dst = ~clk_dst;
   end

   cdc_hs_tx #(
      .DATA_W      (8),
      .NUM_STAGES  (2),
      .TIMEOUT_CYC (20)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .cdc_data      (cdc_data),
      .cdc_req       (cdc_req),
      .cdc_ack_async (cdc_ack_async),
      .tx_done       (tx_done),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .err_clr       (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Receiver model in the destination domain; rx_hold freezes the ack level.
   logic rq1, rq2, ack;
   int   dly_cnt;
   int   rx_dly = 0;
   logic rx_hold = 1'b0;

   assign cdc_ack_async = ack;

   always @(posedge clk_dst or negedge rst_n) begin
      if (!rst_n) begin
         rq1     <= 1'b0;
         rq2     <= 1'b0;
         ack     <= 1'b0;
         dly_cnt <= 0;
      end else begin
         rq1 <= cdc_req;
         rq2 <= rq1;
         if (!rx_hold && (rq2 != ack)) begin
            if (dly_cnt >= rx_dly) begin
               dly_cnt <= 0;
               ack     <= rq2;
               if (rq2) begin
                  if (exp_q.size() == 0) chk("rx_unexpected_word", exp_q.size(), 1);
                  else                   chk("rx_word", cdc_data, exp_q.pop_front());
               end
            end else begin
               dly_cnt <= dly_cnt + 1;
            end
         end
      end
   end

   // cdc_data must not move across an edge where req or synchronized ack was high.
   logic [7:0] mon_data;
   logic       mon_guard = 1'b0;
   logic       mon_arm = 1'b0;

   always @(negedge clk) begin
      if (rst_n && mon_arm && mon_guard) chk("data_stable", cdc_data, mon_data);
      mon_data  = cdc_data;
      mon_guard = cdc_req | dut.ack_s;
      mon_arm   = rst_n;
   end
   always @(negedge rst_n) mon_arm = 1'b0;

   always @(negedge clk) if (rst_n && tx_done) n_done++;

   task automatic send_word(input logic [7:0] d, output int waited);
      waited   = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!tx_ready) begin
         chk("accept_timeout", tx_ready, 1);
      end else begin
         exp_q.push_back(d);
         n_sent++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input logic [7:0] d, output int cyc);
      logic rdy_bad = 1'b0;
      logic dat_bad = 1'b0;
      cyc = 0;
      while (cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (tx_done) break;
         if (tx_ready) rdy_bad = 1'b1;
         if (cdc_data !== d) dat_bad = 1'b1;
      end
      chk("done_seen", tx_done, 1);
      chk("ready_low_in_xfer", rdy_bad, 0);
      chk("data_held_in_xfer", dat_bad, 0);
   endtask

   task automatic timeout_phase(input logic [7:0] d, input logic clr_at_fire, input string tag);
      int w;
      int cyc;
      rx_hold = 1'b1;
      send_word(d, w);
      tx_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk({tag, "_err_pre"}, timeout_err, 0);
      err_clr = clr_at_fire;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      chk({tag, "_err_set"}, timeout_err, 1);
      chk({tag, "_req_held"}, cdc_req, 1);
      repeat (10) @(posedge clk);
      #1;
      chk({tag, "_err_sticky"}, timeout_err, 1);
      chk({tag, "_still_busy"}, busy, 1);
      rx_hold = 1'b0;
      wait_done(d, cyc);
      chk({tag, "_err_after_done"}, timeout_err, 1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk({tag, "_err_cleared"}, timeout_err, 0);
   endtask

   initial begin
      #(5_000_000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int cyc;
      int gap;
      int n;

      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      err_clr  = 1'b0;
      #20;
      chk("rst_req", cdc_req, 0);
      chk("rst_data", cdc_data, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_err", timeout_err, 0);
      #7 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single word
      send_word(8'hA5, w);
      tx_valid = 1'b0;
      chk("t1_req_rise", cdc_req, 1);
      chk("t1_data", cdc_data, 8'hA5);
      chk("t1_ready_low", tx_ready, 0);
      chk("t1_busy", busy, 1);
      wait_done(8'hA5, cyc);
      chk("t1_min_latency", (cyc >= 6), 1);
      @(negedge clk);
      chk("t1_done_one_pulse", tx_done, 0);
      chk("t1_ready_back", tx_ready, 1);
      chk("t1_done_cnt", n_done, 1);
      chk("t1_rx_drained", exp_q.size(), 0);

      // back-to-back with tx_valid held high
      for (int i = 1; i <= 3; i++) begin
         logic [7:0] d;
         d = 8'(i);
         send_word(d, w);
         if (i > 1) chk("t2_accept_after_done", w, 0);
         wait_done(d, cyc);
         if (i == 3) tx_valid = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("t2_done_cnt", n_done, 4);
      chk("t2_rx_drained", exp_q.size(), 0);
      chk("t2_idle", busy, 0);

      // timeout without ack, then late ack completes
      timeout_phase(8'h77, 1'b0, "t3");
      // err_clr coinciding with a new timeout
      timeout_phase(8'h5A, 1'b1, "t6");

      // reset while in WAIT_REL
      send_word(8'hC3, w);
      tx_valid = 1'b0;
      n = 0;
      while (!(busy && !cdc_req) && n < 300) begin
         @(negedge clk);
         n++;
      end
      rx_hold = 1'b1;
      repeat (4) @(negedge clk);
      chk("t4_in_wait_rel", busy && !cdc_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_rst_req", cdc_req, 0);
      chk("t4_rst_ready", tx_ready, 1);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_data", cdc_data, 0);
      n_abort++;
      @(negedge clk);
      rst_n   = 1'b1;
      rx_hold = 1'b0;
      repeat (2) @(negedge clk);
      send_word(8'h3C, w);
      tx_valid = 1'b0;
      chk("t4_fresh_data", cdc_data, 8'h3C);
      wait_done(8'h3C, cyc);
      repeat (2) @(negedge clk);
      chk("t4_done_cnt", n_done, n_sent - n_abort);
      chk("t4_rx_drained", exp_q.size(), 0);

      // random words across clock ratios 1:3 .. 3:1
      for (int blk = 0; blk < 10; blk++) begin
         dst_half = $urandom_range(17, 150) / 10.0;
         rx_dly   = $urandom_range(0, 2);
         for (int k = 0; k < 100; k++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
               tx_valid = 1'b0;
               repeat (gap) @(posedge clk);
               #1;
            end
            send_word(8'($urandom), w);
         end
      end
      tx_valid = 1'b0;
      n = 0;
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("t5_drain_idle", busy, 0);
      repeat (3) @(negedge clk);
      chk("t5_rx_drained", exp_q.size(), 0);
      chk("t5_done_cnt", n_done, n_sent - n_abort);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
